// File: rtl/spi_master_gen.sv
// Parametrised SPI master: configurable word width, SCK divider, per-transfer CPOL/CPHA
// and several active-low slave selects. Every pin-facing output comes straight from a flop.
module spi_master_gen #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2,
  parameter int NUM_CS  = 1,
  parameter int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] ss_n
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

  state_e state_q, state_d;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              sck_q, sck_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic [NUM_CS-1:0] ss_n_q, ss_n_d;

  logic              cs_ok;
  logic              accept;
  logic              tick;
  logic              edge_fire;
  logic              edge_lead;
  logic              edge_final;
  logic [EDGE_W-1:0] edge_next;

  assign cs_ok  = (32'(cs_sel) < 32'(NUM_CS));
  assign accept = (state_q == IDLE) && start && cs_ok;
  assign tick   = (div_q == DIV_LAST);

  // An SCK edge fires at the end of every half-period; the SETUP->XFER step is edge 1.
  always_comb begin
    edge_fire  = 1'b0;
    edge_next  = edge_q + EDGE_W'(1);
    if (tick) begin
      if (state_q == SETUP) begin
        edge_fire = 1'b1;
      end else if ((state_q == XFER) && (edge_q != EDGE_LAST)) begin
        edge_fire = 1'b1;
      end
    end
    edge_lead  = edge_next[0];
    edge_final = (edge_next == EDGE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = SETUP;
      SETUP: if (tick) state_d = XFER;
      XFER:  if (tick && (edge_q == EDGE_LAST)) state_d = HOLD;
      HOLD:  if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div_d     = (state_q == IDLE || tick) ? '0 : div_q + DIV_W'(1);
    edge_d    = edge_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    ss_n_d    = ss_n_q;

    case (state_q)
      IDLE: begin
        sck_d  = cpol;
        mosi_d = 1'b0;
        ss_n_d = '1;
        edge_d = '0;
        if (accept) begin
          cpol_d  = cpol;
          cpha_d  = cpha;
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          mosi_d  = cpha ? mosi_q : tx_data[DATA_W-1];
          for (int i = 0; i < NUM_CS; i++) begin
            ss_n_d[i] = (cs_sel != CS_W'(i));
          end
        end
      end
      SETUP: sck_d = cpol_q;
      HOLD: begin
        sck_d = cpol_q;
        if (tick) begin
          ss_n_d    = '1;
          mosi_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
        end
      end
      default: ;
    endcase

    // cpha=0 samples on leading / shifts on trailing edges; cpha=1 the other way round.
    if (edge_fire) begin
      sck_d  = ~sck_q;
      edge_d = edge_next;
      if (edge_lead ^ cpha_q) begin
        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
      end
      if (cpha_q && edge_lead) begin
        mosi_d  = tx_sh_q[DATA_W-1];
        tx_sh_d = tx_sh_q << 1;
      end else if (!cpha_q && !edge_lead && !edge_final) begin
        mosi_d  = tx_sh_q[DATA_W-2];
        tx_sh_d = tx_sh_q << 1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q     <= '0;
      edge_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      ss_n_q    <= '1;
    end else begin
      div_q     <= div_d;
      edge_q    <= edge_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      ss_n_q    <= ss_n_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign ss_n    = ss_n_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Bench for spi_master_gen: an 8-bit/4-select instance driven against an SPI slave model,
// and a 16-bit divide-by-1 instance run in loopback.
module tb_spi_master_gen;

  localparam int A_DW  = 8;
  localparam int A_DIV = 2;
  localparam int A_NCS = 4;
  localparam int A_CSW = 3;
  localparam int B_DW  = 16;
  localparam int B_DIV = 1;
  localparam int LIMIT = 200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             a_rst, a_start, a_cpol, a_cpha, a_miso;
  logic [A_CSW-1:0] a_cs;
  logic [7:0]       a_tx, a_rx;
  logic             a_busy, a_done, a_sck, a_mosi;
  logic [3:0]       a_ss_n;

  logic             b_rst, b_start, b_cpol, b_cpha, b_miso;
  logic [0:0]       b_cs;
  logic [15:0]      b_tx, b_rx;
  logic             b_busy, b_done, b_sck, b_mosi;
  logic [0:0]       b_ss_n;

  int checks = 0;
  int errors = 0;

  spi_master_gen #(.DATA_W(A_DW), .CLK_DIV(A_DIV), .NUM_CS(A_NCS), .CS_W(A_CSW)) u_a (
    .clk(clk), .rst(a_rst), .start(a_start), .cpol(a_cpol), .cpha(a_cpha),
    .cs_sel(a_cs), .tx_data(a_tx), .rx_data(a_rx), .busy(a_busy), .done(a_done),
    .sck(a_sck), .mosi(a_mosi), .miso(a_miso), .ss_n(a_ss_n)
  );

  spi_master_gen #(.DATA_W(B_DW), .CLK_DIV(B_DIV), .NUM_CS(1)) u_b (
    .clk(clk), .rst(b_rst), .start(b_start), .cpol(b_cpol), .cpha(b_cpha),
    .cs_sel(b_cs), .tx_data(b_tx), .rx_data(b_rx), .busy(b_busy), .done(b_done),
    .sck(b_sck), .mosi(b_mosi), .miso(b_miso), .ss_n(b_ss_n)
  );

  assign b_miso = b_mosi;

  // Slave model: reacts to the pins it sees, shifting out sl_word and capturing mosi.
  logic [7:0] sl_word = 8'h00;
  logic [7:0] sl_cur = 8'h00;
  logic [7:0] sl_rx = 8'h00;
  logic       sl_cpol = 1'b0;
  logic       sl_cpha = 1'b0;
  logic       sl_active = 1'b0;
  logic       sl_prev_sck = 1'b0;
  int         sl_sel = 0;
  int         sl_bit = 0;
  int         sl_nbits = 0;

  always @(negedge clk) begin
    if (a_ss_n[sl_sel] === 1'b0) begin
      if (!sl_active) begin
        sl_active = 1'b1;
        sl_cur    = sl_word;
        sl_rx     = 8'h00;
        sl_nbits  = 0;
        sl_bit    = 0;
        if (!sl_cpha) begin
          a_miso = sl_cur[7];
          sl_bit = 1;
        end
      end else if (a_sck !== sl_prev_sck) begin
        if ((a_sck != sl_cpol) ^ sl_cpha) begin
          sl_rx = {sl_rx[6:0], a_mosi};
          sl_nbits++;
        end else if (sl_bit < 8) begin
          a_miso = sl_cur[7 - sl_bit];
          sl_bit++;
        end
      end
    end else begin
      sl_active = 1'b0;
      a_miso    = 1'b0;
    end
    sl_prev_sck = a_sck;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transfer on instance A, checked against the timing and data rules of the SPI link.
  task automatic applyStimulus(input string tag, input logic cpol, input logic cpha,
                               input logic [2:0] cs, input logic [7:0] tx, input logic [7:0] slave);
    int cyc, toggles, first_edge, ssn_bad, busy_bad, rx_bad, done_cyc;
    logic       prev_sck;
    logic [7:0] rx_before;
    logic [3:0] exp_ssn;
    exp_ssn = ~(4'b0001 << cs);
    @(negedge clk);
    a_cpol = cpol; a_cpha = cpha; a_cs = cs; a_tx = tx;
    sl_cpol = cpol; sl_cpha = cpha; sl_sel = int'(cs); sl_word = slave;
    @(negedge clk);
    checkOutput({tag, " idle sck"}, 32'(a_sck), 32'(cpol));
    checkOutput({tag, " idle ss_n"}, 32'(a_ss_n), 32'hF);
    rx_before = a_rx;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_tx    = ~tx;
    a_cs    = 3'(cs + 3'd1);
    a_cpha  = ~cpha;
    cyc = 1; prev_sck = cpol; toggles = 0; first_edge = 0;
    ssn_bad = 0; busy_bad = 0; rx_bad = 0; done_cyc = 0;
    while (cyc < LIMIT && done_cyc == 0) begin
      if (a_done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        if (a_ss_n !== exp_ssn) ssn_bad++;
        if (a_busy !== 1'b1) busy_bad++;
        if (a_rx !== rx_before) rx_bad++;
        if (a_sck !== prev_sck) begin
          toggles++;
          if (toggles == 1) first_edge = cyc;
        end
        prev_sck = a_sck;
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, " done cycle"}, 32'(done_cyc), 32'(1 + (2 * A_DW + 2) * A_DIV));
    checkOutput({tag, " rx_data"}, 32'(a_rx), 32'(slave));
    checkOutput({tag, " slave saw mosi"}, 32'(sl_rx), 32'(tx));
    checkOutput({tag, " slave bit count"}, 32'(sl_nbits), 32'(A_DW));
    checkOutput({tag, " sck edges"}, 32'(toggles), 32'(2 * A_DW));
    checkOutput({tag, " first sck edge"}, 32'(first_edge), 32'(1 + A_DIV));
    checkOutput({tag, " ss_n bad cycles"}, 32'(ssn_bad), 32'd0);
    checkOutput({tag, " busy bad cycles"}, 32'(busy_bad), 32'd0);
    checkOutput({tag, " rx early change"}, 32'(rx_bad), 32'd0);
    checkOutput({tag, " busy at done"}, 32'(a_busy), 32'd0);
    checkOutput({tag, " ss_n at done"}, 32'(a_ss_n), 32'hF);
    checkOutput({tag, " sck at done"}, 32'(a_sck), 32'(cpol));
    @(negedge clk);
    checkOutput({tag, " done width"}, 32'(a_done), 32'd0);
    a_cpha = cpha;
  endtask

  // Loopback transfer on instance B: whatever is sent must come back unchanged.
  task automatic applyStimulusLoop(input string tag, input logic [15:0] tx, input logic cpol, input logic cpha);
    int cyc, done_cyc;
    @(negedge clk);
    b_tx = tx; b_cpol = cpol; b_cpha = cpha;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_tx    = ~tx;
    cyc = 1; done_cyc = 0;
    while (cyc < LIMIT && done_cyc == 0) begin
      if (b_done === 1'b1) begin
        done_cyc = cyc;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput({tag, " done cycle"}, 32'(done_cyc), 32'(1 + (2 * B_DW + 2) * B_DIV));
    checkOutput({tag, " rx_data"}, 32'(b_rx), 32'(tx));
    checkOutput({tag, " ss_n at done"}, 32'(b_ss_n), 32'h1);
    checkOutput({tag, " busy at done"}, 32'(b_busy), 32'd0);
    checkOutput({tag, " sck at done"}, 32'(b_sck), 32'(cpol));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad_busy, bad_done, bad_ssn, dones, done1, done2, cyc;
    logic [3:0] ssn37, ssn38;
    logic [7:0] rx_first, tx1, tx2, sv1, sv2;

    a_rst = 1'b0; b_rst = 1'b0;
    a_start = 1'b0; a_cpol = 1'b0; a_cpha = 1'b0; a_cs = '0; a_tx = '0;
    b_start = 1'b0; b_cpol = 1'b0; b_cpha = 1'b0; b_cs = '0; b_tx = '0;
    #2;
    a_rst = 1'b1; b_rst = 1'b1;
    #1;
    checkOutput("reset sck", 32'(a_sck), 32'd0);
    checkOutput("reset mosi", 32'(a_mosi), 32'd0);
    checkOutput("reset ss_n", 32'(a_ss_n), 32'hF);
    checkOutput("reset busy", 32'(a_busy), 32'd0);
    checkOutput("reset done", 32'(a_done), 32'd0);
    checkOutput("reset rx_data", 32'(a_rx), 32'd0);
    repeat (3) @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;

    applyStimulus("mode0", 1'b0, 1'b0, 3'd0, 8'hA5, 8'h3C);
    applyStimulus("mode1", 1'b0, 1'b1, 3'd0, 8'h81, 8'h7E);
    applyStimulus("mode2", 1'b1, 1'b0, 3'd0, 8'h81, 8'h7E);
    applyStimulus("mode3", 1'b1, 1'b1, 3'd0, 8'h81, 8'h7E);
    applyStimulus("cs2", 1'b0, 1'b0, 3'd2, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 4; i++) begin
      applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
    end

    // Out-of-range select must be ignored entirely.
    @(negedge clk);
    a_cs = 3'd5; a_start = 1'b1; sl_sel = 0;
    bad_busy = 0; bad_done = 0; bad_ssn = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_busy !== 1'b0) bad_busy++;
      if (a_done !== 1'b0) bad_done++;
      if (a_ss_n !== 4'hF) bad_ssn++;
    end
    a_start = 1'b0;
    checkOutput("cs5 busy", 32'(bad_busy), 32'd0);
    checkOutput("cs5 done", 32'(bad_done), 32'd0);
    checkOutput("cs5 ss_n", 32'(bad_ssn), 32'd0);

    // Mid-transfer start ignored, held start chains a second transfer after one idle cycle.
    tx1 = 8'($urandom); tx2 = 8'($urandom); sv1 = 8'($urandom); sv2 = 8'($urandom);
    @(negedge clk);
    a_cpol = 1'b0; a_cpha = 1'b0; a_cs = 3'd1; a_tx = tx1;
    sl_cpol = 1'b0; sl_cpha = 1'b0; sl_sel = 1; sl_word = sv1;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    dones = 0; done1 = 0; done2 = 0; rx_first = 8'h00; ssn37 = 4'h0; ssn38 = 4'h0;
    for (cyc = 1; cyc <= 80; cyc++) begin
      if (cyc == 10) begin
        a_start = 1'b1; a_tx = tx2; sl_word = sv2;
      end
      if (a_done === 1'b1) begin
        dones++;
        if (dones == 1) begin
          done1 = cyc; rx_first = a_rx;
          checkOutput("chain slave saw tx1", 32'(sl_rx), 32'(tx1));
        end else begin
          done2 = cyc;
        end
      end
      if (cyc == 37) ssn37 = a_ss_n;
      if (cyc == 38) begin
        ssn38 = a_ss_n; a_start = 1'b0;
      end
      @(negedge clk);
    end
    checkOutput("chain first done", 32'(done1), 32'd37);
    checkOutput("chain first rx", 32'(rx_first), 32'(sv1));
    checkOutput("chain idle gap ss_n", 32'(ssn37), 32'hF);
    checkOutput("chain second ss_n", 32'(ssn38), 32'hD);
    checkOutput("chain second done", 32'(done2), 32'd74);
    checkOutput("chain done count", 32'(dones), 32'd2);
    checkOutput("chain second rx", 32'(a_rx), 32'(sv2));
    checkOutput("chain slave saw tx2", 32'(sl_rx), 32'(tx2));

    // Asynchronous reset in the middle of a transfer.
    @(negedge clk);
    a_cs = 3'd3; a_tx = 8'($urandom); sl_sel = 3; sl_word = 8'hFF;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (14) @(negedge clk);
    checkOutput("pre-reset busy", 32'(a_busy), 32'd1);
    a_rst = 1'b1;
    #1;
    checkOutput("async ss_n", 32'(a_ss_n), 32'hF);
    checkOutput("async sck", 32'(a_sck), 32'd0);
    checkOutput("async busy", 32'(a_busy), 32'd0);
    checkOutput("async mosi", 32'(a_mosi), 32'd0);
    checkOutput("async rx_data", 32'(a_rx), 32'd0);
    repeat (2) @(negedge clk);
    a_rst = 1'b0;
    bad_done = 0; bad_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (a_done !== 1'b0) bad_done++;
      if (a_busy !== 1'b0) bad_busy++;
    end
    checkOutput("post-reset done", 32'(bad_done), 32'd0);
    checkOutput("post-reset busy", 32'(bad_busy), 32'd0);
    checkOutput("post-reset rx_data", 32'(a_rx), 32'd0);

    applyStimulusLoop("loop1234", 16'h1234, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulusLoop("looprand", 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
